btb_update_queue: RTL and testbench
===================================

# btb_update_queue

Buffers resolved branches retiring from commit, up to two per cycle, and drains them into the BTB write port at one per cycle. Drops non-branch and redundant updates so the BTB's single write port keeps up with the retire rate. Sits between the commit stage and the BTB's `btb_commit*` inputs. Owns all ordering between simultaneous retirements.

## Interface
- `DEPTH`, 8: queue entries; power of 2, ≥4.
- `COMMIT_WIDTH`, 2: retire slots per cycle; fixed at 2. Slot 0 is the older retirement.
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low; asserted at 0.
- `cm_valid`  in  [COMMIT_WIDTH]  slot carries a resolved control-flow instruction.
- `cm_pc`  in  [COMMIT_WIDTH] × 32  instruction PC.
- `cm_br_type`  in  [COMMIT_WIDTH] × 2  branch type code.
- `cm_npc`  in  [COMMIT_WIDTH] × 32  resolved target.
- `cm_ready`  out  1  queue accepts this cycle's slots.
- `btb_commit`  out  1  write strobe to the BTB.
- `btb_commit_pc`  out  32  PC written to the BTB.
- `btb_commit_pc_type`  out  2  branch type written to the BTB.
- `btb_commit_npc`  out  32  target written to the BTB.
- `q_count`  out  $clog2(DEPTH)+1  current occupancy.
- `drop_count`  out  16  saturating count of filtered slots.

## Operation
- Branch type encoding: 00 NONE, 01 COND, 10 JUMP, 11 RET.
- **Acceptance.** A slot is accepted at the clock edge when `cm_valid[i] & cm_ready`.
- **Commit stage rule.** Commit holds slots while `cm_ready` = 0. Slots that are valid while `cm_ready` = 0 are ignored.
- **Filtering.** Filters apply in order, to accepted slots only:
  1. `cm_br_type` = NONE → drop.
  2. Both slots valid with equal `cm_pc` → drop slot 0; the younger slot wins.
  3. Entry equal to the last-enqueued register (pc, type and npc all equal) → drop.
  - For slot 1, the last-enqueued reference is slot 0 if slot 0 was enqueued this cycle; otherwise it is the register.
- **Drop accounting.** Each dropped slot increments `drop_count`. It saturates at 0xFFFF.
- **Enqueue.** Survivors are enqueued in age order, slot 0 first, at tail and tail+1 (mod DEPTH). The last-enqueued register is updated to the youngest survivor.
- **Drain.** The BTB always accepts, so there is no ready signal.
  - `btb_commit` = (count ≠ 0).
  - Data outputs are driven from the head entry.
  - The head pops at every edge where `btb_commit` = 1.
- **Backpressure.** `cm_ready` = (DEPTH − count) ≥ 2. It uses the registered count and ignores the same-cycle pop, so it is conservative and all-or-nothing.
- **Count update.** count_next = count + pushed − popped, where pushed ∈ {0,1,2} and popped ∈ {0,1}.
- **Pointers.** Head and tail are log2(DEPTH) bits wide and wrap naturally. count disambiguates full from empty.

## Timing
- **Reset values (async).**
  - head = 0, tail = 0, count = 0.
  - Last-enqueued valid = 0, `drop_count` = 0.
  - Outputs: `btb_commit` = 0, `q_count` = 0, `drop_count` = 0, `cm_ready` = 1.
  - Data outputs = 0; storage data is not reset, and outputs are masked to 0 while empty.
- **Latency.**
  - Slot accepted at edge t into an empty queue → `btb_commit` = 1 during cycle t+1; the BTB writes at edge t+1.
  - Two survivors accepted at edge t → written at edges t+1 and t+2.
- **Full queue.** count ≥ DEPTH−1 → `cm_ready` = 0. A push and pop in the same cycle never overflows.
- **Empty queue.** A push at edge t never bypasses to the outputs in cycle t; output data always comes from storage.
- **Mid-operation reset.** Reset mid-operation discards all entries immediately. `btb_commit` deasserts asynchronously.
- **Sustained input.** 2 survivors per cycle sustained → the queue fills, then `cm_ready` toggles, giving 1 per cycle throughput.

## Structure
- **Shared package `bp_pkg`.**
  - `br_type_e`: NONE / COND / JUMP / RET.
  - `btb_upd_t` struct {pc[31:0], br_type, npc[31:0]}.
  - `COMMIT_WIDTH` constant.
  - The BTB and fetch predictor import the same type codes.
- **Sub-module `btb_upd_filter`.** Purely combinational: slot filtering, coalescing and last-enqueued compare. It outputs the push vector, the two survivor entries and the drop increment.
- **Top.** Holds the storage, pointers, counters and output muxing.

## Test plan
- **Single entry.** After reset, slot 0 = {pc 0x100, JUMP, npc 0x200} → `btb_commit` high exactly one cycle later with those values; `q_count` returns to 0.
- **Dual push.** Two distinct COND entries, pc 0x104 and 0x110, in one cycle → written on consecutive cycles in order 0x104 then 0x110.
- **Filtering.**
  - Slot 0 with type NONE → not written; `drop_count` = 1.
  - Both slots with pc 0x300, npcs 0x400 and 0x500 → only npc 0x500 is written; `drop_count` increments by 1.
  - A repeat of the last enqueued entry in a later cycle → dropped.
- **Fill and stall.** Push 2 distinct entries every cycle for 10 cycles, holding slots while not ready → `cm_ready` falls when count ≥ 7. No entry is lost, duplicated or reordered. Exactly one write per cycle once the queue is non-empty.
- **Mid-operation reset.** Assert `reset` = 0 with 5 entries queued, mid-cycle → `btb_commit` = 0 and `q_count` = 0 immediately. No stale entry is written after release.
- **Wrap-around.** Run 3×DEPTH single pushes interleaved with drains → head and tail wrap. Outputs match the reference FIFO model exactly.

Source files
------------

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg: types shared by the branch predictor blocks (BTB, fetch predictor,
// BTB update queue).
//   br_type_e  : 2-bit branch type code written into the BTB.
//   btb_upd_t  : one BTB update record {pc, br_type, npc}.
//   COMMIT_WIDTH : retire slots per cycle; slot 0 is the older retirement.
// ---------------------------------------------------------------------------
package bp_pkg;

   localparam int COMMIT_WIDTH = 2;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_COND = 2'b01,
      BR_JUMP = 2'b10,
      BR_RET  = 2'b11
   } br_type_e;

   typedef struct packed {
      logic [31:0] pc;
      br_type_e    br_type;
      logic [31:0] npc;
   } btb_upd_t;

endpackage

// File: rtl/btb_upd_filter.sv
// ---------------------------------------------------------------------------
// btb_upd_filter: combinational filter for the two retire slots.
//   acc_i      : slot accepted this cycle (valid & ready)
//   slot0_i/1_i: slot records, slot 0 older
//   last_vld_i/last_i : last-enqueued register
//   push_o     : which survivors get enqueued
//   surv0_o/1_o: survivor records (same slot order as inputs)
//   drop_inc_o : number of accepted slots dropped this cycle (0..2)
// ---------------------------------------------------------------------------
module btb_upd_filter
   import bp_pkg::*;
(
   input  logic [1:0] acc_i,
   input  btb_upd_t   slot0_i,
   input  btb_upd_t   slot1_i,
   input  logic       last_vld_i,
   input  btb_upd_t   last_i,
   output logic [1:0] push_o,
   output btb_upd_t   surv0_o,
   output btb_upd_t   surv1_o,
   output logic [1:0] drop_inc_o
);

   logic     live0, live1, coal, keep0, keep1, ref1_vld;
   btb_upd_t ref1;

   always_comb begin
      // Type filter first; coalescing only looks at slots that survived it.
      live0 = acc_i[0] && (slot0_i.br_type != BR_NONE);
      live1 = acc_i[1] && (slot1_i.br_type != BR_NONE);
      // Same PC retiring twice in one cycle: the younger outcome is the one
      // the BTB should hold.
      coal  = live0 && live1 && (slot0_i.pc == slot1_i.pc);
      keep0 = live0 && !coal && !(last_vld_i && (slot0_i == last_i));
      // Slot 1 compares against slot 0 if slot 0 is going in this cycle.
      ref1     = keep0 ? slot0_i : last_i;
      ref1_vld = keep0 || last_vld_i;
      keep1    = live1 && !(ref1_vld && (slot1_i == ref1));
      push_o     = {keep1, keep0};
      surv0_o    = slot0_i;
      surv1_o    = slot1_i;
      drop_inc_o = {1'b0, acc_i[0] & ~keep0} + {1'b0, acc_i[1] & ~keep1};
   end

endmodule

// File: rtl/btb_update_queue.sv
// ---------------------------------------------------------------------------
// btb_update_queue: buffers resolved branches from commit (up to two per
// cycle) and drains them into the BTB write port at one per cycle.
//   clock, reset        : clock; asynchronous active-low reset
//   cm_valid/pc/br_type/npc : retire slots, slot 0 older
//   cm_ready            : all-or-nothing acceptance of this cycle's slots
//   btb_commit*         : BTB write strobe and head-entry data (0 when empty)
//   q_count             : occupancy
//   drop_count          : saturating count of filtered slots
// ---------------------------------------------------------------------------
module btb_update_queue #(
   parameter int DEPTH        = 8,
   parameter int COMMIT_WIDTH = 2
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [COMMIT_WIDTH-1:0]            cm_valid,
   input  logic [COMMIT_WIDTH-1:0][31:0]      cm_pc,
   input  logic [COMMIT_WIDTH-1:0][1:0]       cm_br_type,
   input  logic [COMMIT_WIDTH-1:0][31:0]      cm_npc,
   output logic                               cm_ready,
   output logic                               btb_commit,
   output logic [31:0]                        btb_commit_pc,
   output logic [1:0]                         btb_commit_pc_type,
   output logic [31:0]                        btb_commit_npc,
   output logic [$clog2(DEPTH):0]             q_count,
   output logic [15:0]                        drop_count
);
   import bp_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   btb_upd_t      mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [15:0]   drop_q, drop_d;
   logic          last_vld_q, last_vld_d;
   btb_upd_t      last_q, last_d;

   logic [1:0]    acc, push, drop_inc, n_push;
   logic          pop;
   logic [16:0]   drop_sum;
   btb_upd_t      slot0, slot1, surv0, surv1, wr0, head_e;

   // Uses registered count only, so a full queue stalls commit even if the
   // head pops this cycle; two free slots guarantee no overflow.
   assign cm_ready = (count_q <= CW'(DEPTH - 2));
   assign acc      = cm_valid & {2{cm_ready}};
   assign pop      = (count_q != '0);

   always_comb begin
      slot0 = '{pc: cm_pc[0], br_type: br_type_e'(cm_br_type[0]), npc: cm_npc[0]};
      slot1 = '{pc: cm_pc[1], br_type: br_type_e'(cm_br_type[1]), npc: cm_npc[1]};
   end

   btb_upd_filter u_filter (
      .acc_i      (acc),
      .slot0_i    (slot0),
      .slot1_i    (slot1),
      .last_vld_i (last_vld_q),
      .last_i     (last_q),
      .push_o     (push),
      .surv0_o    (surv0),
      .surv1_o    (surv1),
      .drop_inc_o (drop_inc)
   );

   always_comb begin
      n_push     = {1'b0, push[0]} + {1'b0, push[1]};
      // Compact survivors: the oldest survivor always lands at tail.
      wr0        = push[0] ? surv0 : surv1;
      count_d    = count_q + CW'(n_push) - CW'(pop);
      tail_d     = tail_q + PW'(n_push);
      head_d     = head_q + PW'(pop);
      last_d     = last_q;
      last_vld_d = last_vld_q | (|push);
      if (push[1])      last_d = surv1;
      else if (push[0]) last_d = surv0;
      drop_sum   = {1'b0, drop_q} + 17'(drop_inc);
      drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         drop_q     <= '0;
         last_vld_q <= 1'b0;
         last_q     <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         drop_q     <= drop_d;
         last_vld_q <= last_vld_d;
         last_q     <= last_d;
      end
   end

   // Storage is not reset; outputs are masked while empty instead.
   always_ff @(posedge clock) begin
      if (n_push != 2'd0) mem_q[tail_q] <= wr0;
      if (n_push == 2'd2) mem_q[tail_q + PW'(1)] <= surv1;
   end

   assign head_e             = mem_q[head_q];
   assign btb_commit         = pop;
   assign btb_commit_pc      = pop ? head_e.pc      : '0;
   assign btb_commit_pc_type = pop ? head_e.br_type : BR_NONE;
   assign btb_commit_npc     = pop ? head_e.npc     : '0;
   assign q_count            = count_q;
   assign drop_count         = drop_q;

endmodule

// File: tb/tb_btb_update_queue.sv
// ---------------------------------------------------------------------------
// tb_btb_update_queue: directed bench for btb_update_queue. Inputs change
// 1 time unit after the rising edge; a negedge monitor checks every BTB
// write against a hand-filled queue of expected entries.
// ---------------------------------------------------------------------------
module tb_btb_update_queue;
   import bp_pkg::*;

   localparam int DEPTH = 8;

   logic              clock, reset;
   logic [1:0]        cm_valid;
   logic [1:0][31:0]  cm_pc, cm_npc;
   logic [1:0][1:0]   cm_br_type;
   logic              cm_ready, btb_commit;
   logic [31:0]       btb_commit_pc, btb_commit_npc;
   logic [1:0]        btb_commit_pc_type;
   logic [3:0]        q_count;
   logic [15:0]       drop_count;

   int n_chk  = 0;
   int n_fail = 0;
   int n_stall = 0;
   btb_upd_t exp_q [$];

   btb_update_queue #(.DEPTH(DEPTH), .COMMIT_WIDTH(2)) dut (
      .clock              (clock),
      .reset              (reset),
      .cm_valid           (cm_valid),
      .cm_pc              (cm_pc),
      .cm_br_type         (cm_br_type),
      .cm_npc             (cm_npc),
      .cm_ready           (cm_ready),
      .btb_commit         (btb_commit),
      .btb_commit_pc      (btb_commit_pc),
      .btb_commit_pc_type (btb_commit_pc_type),
      .btb_commit_npc     (btb_commit_npc),
      .q_count            (q_count),
      .drop_count         (drop_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic expq(input logic [31:0] p, input logic [1:0] t, input logic [31:0] n);
      exp_q.push_back('{pc: p, br_type: br_type_e'(t), npc: n});
   endtask

   // Present slots and hold them until accepted; returns 1 unit after the
   // accepting edge.
   task automatic push(input logic [1:0] v,
                       input logic [31:0] p0, input logic [1:0] t0, input logic [31:0] n0,
                       input logic [31:0] p1, input logic [1:0] t1, input logic [31:0] n1);
      logic r;
      r = 1'b0;
      cm_valid = v;
      cm_pc[0] = p0; cm_br_type[0] = t0; cm_npc[0] = n0;
      cm_pc[1] = p1; cm_br_type[1] = t1; cm_npc[1] = n1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clock);
         r = cm_ready;
         @(posedge clock);
         #1;
         if (r) break;
         n_stall++;
      end
      if (!r) chk("accept_timeout", 64'(r), 64'd1);
      cm_valid = 2'b00;
   endtask

   // BTB write monitor.
   always @(negedge clock) begin
      if (btb_commit) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 64'(btb_commit_pc), 64'hDEAD_0000_0000_0000);
         end else begin
            btb_upd_t e;
            e = exp_q.pop_front();
            chk("wr_pc",   64'(btb_commit_pc),      64'(e.pc));
            chk("wr_type", 64'(btb_commit_pc_type), 64'(e.br_type));
            chk("wr_npc",  64'(btb_commit_npc),     64'(e.npc));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      cm_valid = '0; cm_pc = '0; cm_br_type = '0; cm_npc = '0;
      #12;
      chk("rst_commit", 64'(btb_commit), 64'd0);
      chk("rst_count",  64'(q_count),    64'd0);
      chk("rst_drop",   64'(drop_count), 64'd0);
      chk("rst_ready",  64'(cm_ready),   64'd1);
      chk("rst_pc",     64'(btb_commit_pc), 64'd0);
      @(negedge clock);
      reset = 1'b1;
      tick(1);

      // Single entry
      expq(32'h100, 2'b10, 32'h200);
      push(2'b01, 32'h100, 2'b10, 32'h200, 32'h0, 2'b00, 32'h0);
      chk("single_commit", 64'(btb_commit), 64'd1);
      chk("single_count",  64'(q_count),    64'd1);
      chk("single_pc",     64'(btb_commit_pc), 64'h100);
      chk("single_type",   64'(btb_commit_pc_type), 64'd2);
      chk("single_npc",    64'(btb_commit_npc), 64'h200);
      tick(1);
      chk("single_empty",  64'(q_count),    64'd0);
      chk("single_idle",   64'(btb_commit), 64'd0);
      chk("empty_mask_pc", 64'(btb_commit_pc), 64'd0);

      // Dual push
      expq(32'h104, 2'b01, 32'h108);
      expq(32'h110, 2'b01, 32'h120);
      push(2'b11, 32'h104, 2'b01, 32'h108, 32'h110, 2'b01, 32'h120);
      chk("dual_count0", 64'(q_count), 64'd2);
      chk("dual_pc0",    64'(btb_commit_pc), 64'h104);
      tick(1);
      chk("dual_count1", 64'(q_count), 64'd1);
      chk("dual_pc1",    64'(btb_commit_pc), 64'h110);
      tick(1);
      chk("dual_empty",  64'(q_count), 64'd0);

      // Type NONE dropped
      push(2'b01, 32'h500, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0);
      chk("none_drop",  64'(drop_count), 64'd1);
      chk("none_count", 64'(q_count),    64'd0);

      // Same PC in both slots: younger wins
      expq(32'h300, 2'b01, 32'h500);
      push(2'b11, 32'h300, 2'b01, 32'h400, 32'h300, 2'b01, 32'h500);
      chk("coal_drop",  64'(drop_count), 64'd2);
      chk("coal_count", 64'(q_count),    64'd1);
      chk("coal_npc",   64'(btb_commit_npc), 64'h500);
      tick(1);

      // Repeat of last enqueued entry
      push(2'b01, 32'h300, 2'b01, 32'h500, 32'h0, 2'b00, 32'h0);
      chk("rep_drop",  64'(drop_count), 64'd3);
      chk("rep_count", 64'(q_count),    64'd0);
      expq(32'h700, 2'b11, 32'h710);
      push(2'b01, 32'h700, 2'b11, 32'h710, 32'h0, 2'b00, 32'h0);
      chk("rep_new_drop", 64'(drop_count), 64'd3);
      push(2'b11, 32'h720, 2'b00, 32'h0, 32'h700, 2'b11, 32'h710);
      chk("rep_slot1_drop",  64'(drop_count), 64'd5);
      chk("rep_slot1_count", 64'(q_count),    64'd0);
      expq(32'h700, 2'b11, 32'h714);
      push(2'b01, 32'h700, 2'b11, 32'h714, 32'h0, 2'b00, 32'h0);
      chk("rep_diff_drop",  64'(drop_count), 64'd5);
      chk("rep_diff_count", 64'(q_count),    64'd1);
      tick(2);

      // Fill and stall: counts after each accept are 2,3,4,5,6,7,7,7,7,7
      n_stall = 0;
      for (int k = 0; k < 10; k++) begin
         logic [31:0] pa, pb;
         pa = 32'h1000 + 32'(8 * k);
         pb = pa + 32'h4;
         expq(pa, 2'b01, pa + 32'h80);
         expq(pb, 2'b01, pb + 32'h80);
         push(2'b11, pa, 2'b01, pa + 32'h80, pb, 2'b01, pb + 32'h80);
         chk("fill_count", 64'(q_count), (k < 5) ? 64'(k + 2) : 64'd7);
      end
      chk("fill_stalls", 64'(n_stall), 64'd4);
      chk("fill_not_ready", 64'(cm_ready), 64'd0);
      tick(6);
      chk("fill_drain_rate", 64'(q_count), 64'd1);
      tick(1);
      chk("fill_drained", 64'(btb_commit), 64'd0);
      chk("fill_leftover", 64'(exp_q.size()), 64'd0);

      // Mid-operation reset with 5 entries queued
      for (int k = 0; k < 4; k++) begin
         logic [31:0] pa;
         pa = 32'h3000 + 32'(8 * k);
         expq(pa, 2'b10, pa + 32'h10);
         expq(pa + 32'h4, 2'b10, pa + 32'h14);
         push(2'b11, pa, 2'b10, pa + 32'h10, pa + 32'h4, 2'b10, pa + 32'h14);
      end
      chk("mrst_pre_count", 64'(q_count), 64'd5);
      #2;
      reset = 1'b0;
      #1;
      chk("mrst_commit", 64'(btb_commit), 64'd0);
      chk("mrst_count",  64'(q_count),    64'd0);
      chk("mrst_drop",   64'(drop_count), 64'd0);
      chk("mrst_ready",  64'(cm_ready),   64'd1);
      exp_q.delete();
      @(negedge clock);
      #1;
      reset = 1'b1;
      tick(4);
      chk("mrst_post_count",  64'(q_count),    64'd0);
      chk("mrst_post_commit", 64'(btb_commit), 64'd0);

      // Wrap-around: 3*DEPTH pushes, every 4th a pair, some idle cycles
      for (int k = 0; k < 3 * DEPTH; k++) begin
         logic [31:0] pa;
         logic [1:0]  t;
         pa = 32'h2000 + 32'(16 * k);
         t  = 2'(k % 3 + 1);
         expq(pa, t, pa + 32'h40 + 32'(k));
         if (k % 4 == 0) begin
            expq(pa + 32'h8, t, pa + 32'h48);
            push(2'b11, pa, t, pa + 32'h40 + 32'(k), pa + 32'h8, t, pa + 32'h48);
         end else begin
            push(2'b01, pa, t, pa + 32'h40 + 32'(k), 32'h0, 2'b00, 32'h0);
         end
         if (k % 5 == 4) tick(1);
      end
      tick(4);
      chk("wrap_leftover", 64'(exp_q.size()), 64'd0);
      chk("wrap_count",    64'(q_count),      64'd0);
      chk("wrap_drop",     64'(drop_count),   64'd0);
      chk("wrap_mask_npc", 64'(btb_commit_npc), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
